// File: rtl/bus_responder_pkg.sv
// Shared constants for the bus responder: IO page addresses, STATUS bit
// positions and the UART transmitter state encoding.
package bus_responder_pkg;

    localparam logic [15:0] ADDR_TXDATA   = 16'hFF00;
    localparam logic [15:0] ADDR_STATUS   = 16'hFF01;
    localparam logic [15:0] ADDR_GPIO_OUT = 16'hFF02;
    localparam logic [15:0] ADDR_GPIO_IN  = 16'hFF03;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/bus_responder_uart_tx.sv
// 8N1 UART transmitter, LSB first. Pulls one byte per frame from a
// valid/ready source while idle; tx is registered and idles high.
module bus_responder_uart_tx
    import bus_responder_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);

    uart_state_t   r_state, w_state_nxt;
    logic [BW-1:0] r_baud, w_baud_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_tx, w_tx_nxt;
    logic          w_baud_end;

    assign w_baud_end = (r_baud == BW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
        if (rst) begin
            r_state <= UART_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        o_ready     = 1'b0;
        case (r_state)
            UART_IDLE: begin
                o_ready    = 1'b1;
                w_baud_nxt = '0;
                if (i_valid) begin
                    w_shift_nxt = i_data;
                    w_state_nxt = UART_START;
                end
            end
            UART_START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = UART_DATA;
                end
            end
            UART_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = UART_STOP;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                    end
                end
            end
            UART_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = UART_IDLE;
                end
            end
            default: w_state_nxt = UART_IDLE;
        endcase

        // Line level follows the state being entered so tx changes on the same edge as the state.
        case (w_state_nxt)
            UART_START: w_tx_nxt = 1'b0;
            UART_DATA:  w_tx_nxt = w_shift_nxt[0];
            default:    w_tx_nxt = 1'b1;
        endcase
    end

    assign o_tx   = r_tx;
    assign o_busy = (r_state != UART_IDLE);

endmodule

// File: rtl/bus_responder.sv
// CPU byte-bus slave: synchronous RAM, UART TX FIFO and GPIO registers on
// the 0xFF00 IO page. Read data is registered with one cycle of latency.
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int RAM_AW       = 15,
    parameter     INIT_FILE    = "",
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    output logic [7:0]  rdata,
    output logic        tx,
    output logic [7:0]  gpio_out,
    input  logic [7:0]  gpio_in
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    r_ram [2**RAM_AW];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [7:0]    r_gpio_out, r_gpio_s1, r_gpio_s2;
    logic [7:0]    r_rdata;

    logic              w_in_ram, w_full, w_empty, w_push_req, w_push, w_pop;
    logic              w_uart_ready, w_uart_busy;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [7:0]        w_status, w_rdata_nxt, w_fifo_head;

    assign w_in_ram    = ((addr >> RAM_AW) == 16'd0);
    assign w_ram_idx   = addr[RAM_AW-1:0];
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push_req  = we && (addr == ADDR_TXDATA);
    assign w_push      = w_push_req && !w_full;
    assign w_pop       = !w_empty && w_uart_ready;
    assign w_fifo_head = r_fifo[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (we && w_in_ram) r_ram[w_ram_idx] <= wdata;
        if (w_push) r_fifo[r_wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_gpio_out <= '0;
            r_gpio_s1  <= '0;
            r_gpio_s2  <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            // A full-FIFO push stays dropped even when the UART pops in the same cycle.
            if (w_push_req && w_full) r_ovf <= 1'b1;
            else if (we && addr == ADDR_STATUS) r_ovf <= 1'b0;
            if (we && addr == ADDR_GPIO_OUT) r_gpio_out <= wdata;
            r_gpio_s1 <= gpio_in;
            r_gpio_s2 <= r_gpio_s1;
            r_rdata   <= w_rdata_nxt;
        end
    end

    always_comb begin
        w_status           = '0;
        w_status[ST_FULL]  = w_full;
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_BUSY]  = w_uart_busy;
        w_status[ST_OVF]   = r_ovf;

        w_rdata_nxt = '0;
        if (w_in_ram)                    w_rdata_nxt = r_ram[w_ram_idx];
        else if (addr == ADDR_STATUS)    w_rdata_nxt = w_status;
        else if (addr == ADDR_GPIO_OUT)  w_rdata_nxt = r_gpio_out;
        else if (addr == ADDR_GPIO_IN)   w_rdata_nxt = r_gpio_s2;
    end

    bus_responder_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk     (clk),
        .rst     (rst),
        .i_valid (!w_empty),
        .i_data  (w_fifo_head),
        .o_ready (w_uart_ready),
        .o_tx    (tx),
        .o_busy  (w_uart_busy)
    );

    assign rdata    = r_rdata;
    assign gpio_out = r_gpio_out;

endmodule
